// File: rtl/if_stage_if.sv
// Handshake and SRAM bundle around the instruction-fetch stage.
// The master side is the fetch stage; the slave side is decode plus the instruction SRAM.
interface if_stage_if;
  logic        ds_allowin;
  logic [33:0] br_bus;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;

  modport master (
    input  ds_allowin, br_bus, inst_sram_rdata,
    output fs_to_ds_valid, fs_to_ds_bus,
    output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata
  );

  modport slave (
    output ds_allowin, br_bus, inst_sram_rdata,
    input  fs_to_ds_valid, fs_to_ds_bus,
    input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata
  );
endinterface

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: next-PC generation, 1-cycle SRAM fetch, and
// instruction/branch-target holding buffers for when decode back-pressures.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input  logic        clk,
  input  logic        reset,
  if_stage_if.master  fs_if
);

  logic        fs_valid_q, fs_valid_d;
  logic [31:0] fs_pc_q, fs_pc_d;
  logic        inst_buf_valid_q, inst_buf_valid_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic        br_pend_valid_q, br_pend_valid_d;
  logic [31:0] br_pend_target_q, br_pend_target_d;

  logic        br_stall, br_taken;
  logic [31:0] br_target;
  logic        to_fs_valid, pre_ready_go, fs_allowin, issue;
  logic [31:0] seq_pc, nextpc, fs_inst;

  assign br_stall  = fs_if.br_bus[33];
  assign br_taken  = fs_if.br_bus[32];
  assign br_target = fs_if.br_bus[31:0];

  assign to_fs_valid  = ~reset;
  assign pre_ready_go = ~br_stall;
  assign seq_pc       = fs_pc_q + 32'd4;

  // A parked branch target outranks a live one: it was decided earlier.
  assign nextpc = br_pend_valid_q          ? br_pend_target_q :
                  (br_taken & ~br_stall)   ? br_target        :
                                             seq_pc;

  assign fs_allowin = ~fs_valid_q | fs_if.ds_allowin;
  assign issue      = to_fs_valid & pre_ready_go & fs_allowin;
  assign fs_inst    = inst_buf_valid_q ? inst_buf_q : fs_if.inst_sram_rdata;

  assign fs_if.inst_sram_en    = issue;
  assign fs_if.inst_sram_wen   = 4'h0;
  assign fs_if.inst_sram_addr  = nextpc;
  assign fs_if.inst_sram_wdata = 32'h0;
  assign fs_if.fs_to_ds_valid  = fs_valid_q;
  assign fs_if.fs_to_ds_bus    = {fs_inst, fs_pc_q};

  always_comb begin
    fs_valid_d       = fs_valid_q;
    fs_pc_d          = fs_pc_q;
    inst_buf_valid_d = inst_buf_valid_q;
    inst_buf_d       = inst_buf_q;
    br_pend_valid_d  = br_pend_valid_q;
    br_pend_target_d = br_pend_target_q;

    if (fs_allowin)
      fs_valid_d = to_fs_valid & pre_ready_go;
    if (issue)
      fs_pc_d = nextpc;

    // SRAM data lives for one cycle only, so grab it the moment decode stalls.
    if (fs_valid_q & fs_if.ds_allowin) begin
      inst_buf_valid_d = 1'b0;
    end else if (fs_valid_q & ~inst_buf_valid_q & ~fs_if.ds_allowin) begin
      inst_buf_valid_d = 1'b1;
      inst_buf_d       = fs_if.inst_sram_rdata;
    end

    if (issue) begin
      br_pend_valid_d = 1'b0;
    end else if (br_taken & ~br_stall) begin
      br_pend_valid_d  = 1'b1;
      br_pend_target_d = br_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid_q       <= 1'b0;
      fs_pc_q          <= RESET_PC - 32'd4;
      inst_buf_valid_q <= 1'b0;
      inst_buf_q       <= 32'h0;
      br_pend_valid_q  <= 1'b0;
      br_pend_target_q <= 32'h0;
    end else begin
      fs_valid_q       <= fs_valid_d;
      fs_pc_q          <= fs_pc_d;
      inst_buf_valid_q <= inst_buf_valid_d;
      inst_buf_q       <= inst_buf_d;
      br_pend_valid_q  <= br_pend_valid_d;
      br_pend_target_q <= br_pend_target_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed per-cycle vectors for if_stage, plus a hand sequence for
// overwriting a parked branch target.
module tb_if_stage;

  logic clk;
  logic reset;
  if_stage_if bus_if ();

  if_stage #(.RESET_PC(32'hbfc00000)) dut (
    .clk   (clk),
    .reset (reset),
    .fs_if (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ds;
    logic        stall;
    logic        taken;
    logic [31:0] tgt;
    logic [31:0] rdata;
    logic        en;
    logic [31:0] addr;
    logic        valid;
    logic [63:0] bus;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic vec_t mk(logic rst, logic ds, logic stall, logic taken,
                              logic [31:0] tgt, logic [31:0] rdata, logic en,
                              logic [31:0] addr, logic valid, logic [31:0] inst,
                              logic [31:0] pc);
    vec_t v;
    v.rst = rst; v.ds = ds; v.stall = stall; v.taken = taken; v.tgt = tgt;
    v.rdata = rdata; v.en = en; v.addr = addr; v.valid = valid; v.bus = {inst, pc};
    return v;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic rst, logic ds, logic stall, logic taken,
                       logic [31:0] tgt, logic [31:0] rdata);
    reset                  = rst;
    bus_if.ds_allowin      = ds;
    bus_if.br_bus          = {stall, taken, tgt};
    bus_if.inst_sram_rdata = rdata;
  endtask

  task automatic check_outs(string tag, logic en, logic [31:0] addr, logic valid,
                            logic [63:0] bus);
    check({tag, ".en"},    {63'h0, bus_if.inst_sram_en},    {63'h0, en});
    check({tag, ".addr"},  {32'h0, bus_if.inst_sram_addr},  {32'h0, addr});
    check({tag, ".valid"}, {63'h0, bus_if.fs_to_ds_valid},  {63'h0, valid});
    if (valid)
      check({tag, ".bus"}, bus_if.fs_to_ds_bus, bus);
  endtask

  initial begin
    // rst ds st tk target        rdata         en addr          vl inst          pc
    vecs.push_back(mk(1,1,0,0,32'h0,        32'h0,        0,32'hbfc00000,0,32'h0,        32'h0));
    vecs.push_back(mk(1,1,0,0,32'h0,        32'h0,        0,32'hbfc00000,0,32'h0,        32'h0));
    vecs.push_back(mk(0,1,0,0,32'h0,        32'h0,        1,32'hbfc00000,0,32'h0,        32'h0));
    vecs.push_back(mk(0,1,0,0,32'h0,        32'h3c080001, 1,32'hbfc00004,1,32'h3c080001, 32'hbfc00000));
    // decode stalls with pc bfc00004 in IF, SRAM data then goes stale
    vecs.push_back(mk(0,0,0,0,32'h0,        32'h24080001, 0,32'hbfc00008,1,32'h24080001, 32'hbfc00004));
    vecs.push_back(mk(0,0,0,0,32'h0,        32'hdeadbeef, 0,32'hbfc00008,1,32'h24080001, 32'hbfc00004));
    vecs.push_back(mk(0,0,0,0,32'h0,        32'hdeadbeef, 0,32'hbfc00008,1,32'h24080001, 32'hbfc00004));
    vecs.push_back(mk(0,0,0,0,32'h0,        32'hdeadbeef, 0,32'hbfc00008,1,32'h24080001, 32'hbfc00004));
    vecs.push_back(mk(0,1,0,0,32'h0,        32'hdeadbeef, 1,32'hbfc00008,1,32'h24080001, 32'hbfc00004));
    vecs.push_back(mk(0,1,0,0,32'h0,        32'h8c090010, 1,32'hbfc0000c,1,32'h8c090010, 32'hbfc00008));
    // taken branch with issue allowed
    vecs.push_back(mk(0,1,0,1,32'hbfc00100, 32'h11111111, 1,32'hbfc00100,1,32'h11111111, 32'hbfc0000c));
    vecs.push_back(mk(0,1,0,0,32'h0,        32'h22222222, 1,32'hbfc00104,1,32'h22222222, 32'hbfc00100));
    // taken branch while decode stalls: target parked
    vecs.push_back(mk(0,0,0,1,32'hbfc00200, 32'h33333333, 0,32'hbfc00200,1,32'h33333333, 32'hbfc00104));
    vecs.push_back(mk(0,0,0,0,32'h0,        32'h44444444, 0,32'hbfc00200,1,32'h33333333, 32'hbfc00104));
    vecs.push_back(mk(0,1,0,0,32'h0,        32'h44444444, 1,32'hbfc00200,1,32'h33333333, 32'hbfc00104));
    vecs.push_back(mk(0,1,0,0,32'h0,        32'h55555555, 1,32'hbfc00204,1,32'h55555555, 32'hbfc00200));
    // br_stall: bubble, frozen pc, taken under stall ignored
    vecs.push_back(mk(0,1,1,0,32'h0,        32'h66666666, 0,32'hbfc00208,1,32'h66666666, 32'hbfc00204));
    vecs.push_back(mk(0,1,1,1,32'hbfc00abc, 32'h77777777, 0,32'hbfc00208,0,32'h0,        32'h0));
    vecs.push_back(mk(0,1,0,1,32'hbfc00300, 32'h77777777, 1,32'hbfc00300,0,32'h0,        32'h0));
    vecs.push_back(mk(0,1,0,0,32'h0,        32'h88888888, 1,32'hbfc00304,1,32'h88888888, 32'hbfc00300));
    // fill both buffers, then reset during a stall
    vecs.push_back(mk(0,0,0,1,32'hbfc00400, 32'h99999999, 0,32'hbfc00400,1,32'h99999999, 32'hbfc00304));
    vecs.push_back(mk(0,0,1,0,32'h0,        32'haaaaaaaa, 0,32'hbfc00400,1,32'h99999999, 32'hbfc00304));
    vecs.push_back(mk(1,0,1,0,32'h0,        32'haaaaaaaa, 0,32'hbfc00400,1,32'h99999999, 32'hbfc00304));
    vecs.push_back(mk(1,0,0,0,32'h0,        32'haaaaaaaa, 0,32'hbfc00000,0,32'h0,        32'h0));
    vecs.push_back(mk(0,1,0,0,32'h0,        32'h0,        1,32'hbfc00000,0,32'h0,        32'h0));
    vecs.push_back(mk(0,1,0,0,32'h0,        32'h3c080001, 1,32'hbfc00004,1,32'h3c080001, 32'hbfc00000));

    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].ds, vecs[i].stall, vecs[i].taken, vecs[i].tgt, vecs[i].rdata);
      @(negedge clk);
      check_outs($sformatf("vec%0d", i), vecs[i].en, vecs[i].addr, vecs[i].valid, vecs[i].bus);
      check($sformatf("vec%0d.wen", i),   {60'h0, bus_if.inst_sram_wen},   64'h0);
      check($sformatf("vec%0d.wdata", i), {32'h0, bus_if.inst_sram_wdata}, 64'h0);
      @(posedge clk); #1;
    end

    // IF holds pc bfc00004; a second taken branch overwrites the parked target
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hbfc00500, 32'h000000ab);
    @(negedge clk);
    check_outs("ovr1", 1'b0, 32'hbfc00500, 1'b1, {32'h000000ab, 32'hbfc00004});
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hbfc00600, 32'h000000ff);
    @(negedge clk);
    check_outs("ovr2", 1'b0, 32'hbfc00500, 1'b1, {32'h000000ab, 32'hbfc00004});
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h000000ff);
    @(negedge clk);
    check_outs("ovr3", 1'b1, 32'hbfc00600, 1'b1, {32'h000000ab, 32'hbfc00004});
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h000000cd);
    @(negedge clk);
    check_outs("ovr4", 1'b1, 32'hbfc00604, 1'b1, {32'h000000cd, 32'hbfc00600});
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
